bnn_sequencer: RTL and testbench
================================

BNN_SEQUENCER -- requirements
Module: bnn_sequencer

Interface
REQ-001 SHALL have parameter PARAM_BITS, default 256, meaning the total neuron-chain parameter bits; it SHALL be a multiple of 8 and at least 8.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 2, meaning the wait cycles (at least 1) between the last input strobe and sampling of bnn_y.
REQ-003 clk  input  1  system clock; all state SHALL change on its rising edge.
REQ-004 rst_n  input  1  asynchronous reset, active-low.
REQ-005 cfg_start  input  1  single-cycle request to start a parameter load.
REQ-006 cfg_data  input  8  parameter byte, shifted out MSB first.
REQ-007 cfg_valid / cfg_ready  input / output  1 / 1  handshake for parameter bytes.
REQ-008 configured  output  1  high once a full parameter load has completed.
REQ-009 busy  output  1  high in any state other than IDLE or READY.
REQ-010 in_data, in_valid / in_ready  input 8, input 1 / output 1  handshake for the inference input byte.
REQ-011 out_data, out_valid / out_ready  output 8, output 1 / input 1  handshake for the inference result.
REQ-012 bnn_clk, bnn_setup, bnn_param, bnn_bank_hi  output  1 each  datapath user-clock strobe, setup, serial parameter bit, and nibble bank select.
REQ-013 bnn_x  output  4  datapath input nibble.
REQ-014 bnn_y  input  8  datapath output byte.

Function
REQ-015 The FSM SHALL have exactly these states: IDLE, LOAD_WAIT, LOAD_SHIFT, READY, INF_LO, INF_HI, SETTLE, RESULT.
REQ-016 Each datapath step SHALL take 2 cycles: phase 0 with bnn_clk=0 and the data outputs driven, then phase 1 with bnn_clk=1 and the data outputs held.
REQ-017 cfg_start SHALL be honoured only in IDLE or READY; it SHALL clear configured, zero the bit counter, and move the FSM to LOAD_WAIT.
REQ-018 cfg_start SHALL be ignored in every other state.
REQ-019 cfg_ready SHALL be 1 only in LOAD_WAIT.
REQ-020 A cfg_valid&cfg_ready handshake SHALL latch cfg_data and move the FSM to LOAD_SHIFT.
REQ-021 LOAD_SHIFT SHALL emit 8 steps (16 cycles), bnn_param = byte bit 7 down to bit 0, with bnn_setup=1 for all of them.
REQ-022 bnn_setup SHALL be 1 throughout LOAD_WAIT and LOAD_SHIFT, and 0 in all other states.
REQ-023 After each byte, the bit counter SHALL advance by 8; below PARAM_BITS the FSM SHALL return to LOAD_WAIT.
REQ-024 When the counter equals PARAM_BITS, the FSM SHALL go to READY and set configured=1 on the same edge.
REQ-025 Between bytes, bnn_clk SHALL stay 0, with no strobe emitted while waiting.
REQ-026 in_ready SHALL be 1 only in READY with configured=1.
REQ-027 in_valid in any other state SHALL be ignored and SHALL NOT be latched.
REQ-028 For an input handshake at cycle T, the block SHALL perform:
- INF_LO step in cycles T+1..T+2 with bnn_bank_hi=0, bnn_x=in_data[3:0];
- INF_HI step in cycles T+3..T+4 with bnn_bank_hi=1, bnn_x=in_data[7:4].
REQ-029 SETTLE SHALL last SETTLE_CYCLES cycles, and out_data SHALL capture bnn_y at the edge ending the last SETTLE cycle.
REQ-030 out_valid SHALL assert in cycle T+5+SETTLE_CYCLES (RESULT state).
REQ-031 out_valid and out_data SHALL hold stable until out_valid&out_ready, after which the FSM SHALL return to READY on the next edge; a result is never dropped.
REQ-032 With out_ready already high at out_valid rise, the result SHALL be consumed in that single cycle.
REQ-033 bnn_x, bnn_bank_hi and bnn_param SHALL be 0 whenever not actively driving a step.
REQ-034 The bit counter SHALL be ceil(log2(PARAM_BITS+1)) bits wide and SHALL NOT wrap.
REQ-035 A cfg_valid with no prior cfg_start SHALL be ignored (cfg_ready=0).

Reset
REQ-036 On rst_n=0, the block SHALL immediately and asynchronously go to IDLE and drive all outputs to 0: configured, busy, cfg_ready, in_ready, out_valid, out_data, bnn_* all 0.
REQ-037 Reset mid-load or mid-inference SHALL abort the operation; configured SHALL stay 0 until a new full load completes.
REQ-038 Reset deassertion SHALL be synchronised externally; the block SHALL leave IDLE only on cfg_start.

Verification
REQ-039 Full load: PARAM_BITS=16, cfg_start, bytes 0xA5 then 0x3C -> bnn_param sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0 sampled on bnn_clk rises, bnn_setup=1 throughout, configured=1 after the 16th strobe, busy=0.
REQ-040 Inference latency: configured, SETTLE_CYCLES=2, in_data=0x7E at cycle T, bnn_y tied to 0x5B -> strobes at T+2 (x=0xE, bank 0) and T+4 (x=0x7, bank 1), out_valid at T+7, out_data=0x5B.
REQ-041 Backpressure: out_ready held 0 for 10 cycles while bnn_y changes to 0x00 -> out_data stays 0x5B, in_ready=0; out_ready=1 -> READY next cycle.
REQ-042 Gating: in_valid=1 before configured, and cfg_start during INF_HI -> in_ready=0, no strobe emitted, cfg_start ignored, inference completes normally.
REQ-043 Reset mid-load: rst_n=0 after 5 of 16 bits -> all outputs 0 the same cycle, configured=0; a subsequent full reload succeeds.
REQ-044 Reconfigure: cfg_start in READY -> configured=0 the next cycle, in_ready=0 until the new load completes.

Source files
------------

// File: rtl/bnn_sequencer.sv
// Sequencer for a serial-configured binarised neural-network datapath: streams
// parameter bytes in bit-serially, then runs one nibble-pair inference per input.
//
// state      | meaning
// IDLE       | unconfigured, waiting for cfg_start
// LOAD_WAIT  | setup asserted, waiting for the next parameter byte
// LOAD_SHIFT | shifting one parameter byte out MSB first, one bit per step
// READY      | configured, accepting an inference input byte
// INF_LO     | driving the low input nibble (bank 0)
// INF_HI     | driving the high input nibble (bank 1)
// SETTLE     | waiting for bnn_y to settle, captured on the last cycle
// RESULT     | holding out_data until the consumer takes it
module bnn_sequencer #(
  parameter int PARAM_BITS    = 256,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_start,
  input  logic [7:0] cfg_data,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  output logic       configured,
  output logic       busy,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       bnn_clk,
  output logic       bnn_setup,
  output logic       bnn_param,
  output logic       bnn_bank_hi,
  output logic [3:0] bnn_x,
  input  logic [7:0] bnn_y
);

  localparam int CW = $clog2(PARAM_BITS + 1);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_WAIT, S_LOAD_SHIFT, S_READY,
    S_INF_LO, S_INF_HI, S_SETTLE, S_RESULT
  } state_t;

  state_t          r_state;
  logic            r_phase;
  logic [2:0]      r_bit_idx;
  logic [6:0]      r_shift;
  logic [3:0]      r_hi;
  logic [CW-1:0]   r_bit_cnt;
  logic [SW-1:0]   r_settle;
  logic [CW-1:0]   w_cnt_next;

  assign w_cnt_next = r_bit_cnt + CW'(8);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_phase     <= 1'b0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_hi        <= '0;
      r_bit_cnt   <= '0;
      r_settle    <= '0;
      cfg_ready   <= 1'b0;
      configured  <= 1'b0;
      busy        <= 1'b0;
      in_ready    <= 1'b0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      bnn_clk     <= 1'b0;
      bnn_setup   <= 1'b0;
      bnn_param   <= 1'b0;
      bnn_bank_hi <= 1'b0;
      bnn_x       <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_READY: begin
          if (cfg_start) begin
            r_state    <= S_LOAD_WAIT;
            configured <= 1'b0;
            r_bit_cnt  <= '0;
            cfg_ready  <= 1'b1;
            bnn_setup  <= 1'b1;
            busy       <= 1'b1;
            in_ready   <= 1'b0;
          end else if (in_valid && in_ready) begin
            // low nibble goes out immediately; keep only the high one
            r_state     <= S_INF_LO;
            r_hi        <= in_data[7:4];
            bnn_x       <= in_data[3:0];
            bnn_bank_hi <= 1'b0;
            bnn_clk     <= 1'b0;
            r_phase     <= 1'b0;
            busy        <= 1'b1;
            in_ready    <= 1'b0;
          end
        end
        S_LOAD_WAIT: begin
          if (cfg_valid) begin
            r_state   <= S_LOAD_SHIFT;
            cfg_ready <= 1'b0;
            r_shift   <= cfg_data[6:0];
            bnn_param <= cfg_data[7];
            r_bit_idx <= 3'd7;
            r_phase   <= 1'b0;
          end
        end
        S_LOAD_SHIFT: begin
          if (!r_phase) begin
            r_phase <= 1'b1;
            bnn_clk <= 1'b1;
          end else begin
            r_phase <= 1'b0;
            bnn_clk <= 1'b0;
            if (r_bit_idx == 3'd0) begin
              bnn_param <= 1'b0;
              r_bit_cnt <= w_cnt_next;
              if (w_cnt_next == CW'(PARAM_BITS)) begin
                r_state    <= S_READY;
                configured <= 1'b1;
                busy       <= 1'b0;
                bnn_setup  <= 1'b0;
                in_ready   <= 1'b1;
              end else begin
                r_state   <= S_LOAD_WAIT;
                cfg_ready <= 1'b1;
              end
            end else begin
              r_bit_idx <= r_bit_idx - 3'd1;
              bnn_param <= r_shift[6];
              r_shift   <= {r_shift[5:0], 1'b0};
            end
          end
        end
        S_INF_LO: begin
          if (!r_phase) begin
            r_phase <= 1'b1;
            bnn_clk <= 1'b1;
          end else begin
            r_phase     <= 1'b0;
            bnn_clk     <= 1'b0;
            r_state     <= S_INF_HI;
            bnn_x       <= r_hi;
            bnn_bank_hi <= 1'b1;
          end
        end
        S_INF_HI: begin
          if (!r_phase) begin
            r_phase <= 1'b1;
            bnn_clk <= 1'b1;
          end else begin
            r_phase     <= 1'b0;
            bnn_clk     <= 1'b0;
            bnn_x       <= '0;
            bnn_bank_hi <= 1'b0;
            r_state     <= S_SETTLE;
            r_settle    <= SW'(SETTLE_CYCLES - 1);
          end
        end
        S_SETTLE: begin
          if (r_settle == '0) begin
            out_data  <= bnn_y;
            out_valid <= 1'b1;
            r_state   <= S_RESULT;
          end else begin
            r_settle <= r_settle - SW'(1);
          end
        end
        S_RESULT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= S_READY;
            busy      <= 1'b0;
            in_ready  <= configured;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_sequencer.sv
// Scoreboard bench for bnn_sequencer: expected strobes and results are queued by
// the stimulus thread and checked by an independent negedge monitor.
module tb_bnn_sequencer;
  localparam int PB = 16;
  localparam int SC = 2;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       cfg_start = 1'b0, cfg_valid = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] cfg_data = '0, in_data = '0, bnn_y = '0;
  logic       cfg_ready, configured, busy, in_ready, out_valid;
  logic       bnn_clk, bnn_setup, bnn_param, bnn_bank_hi;
  logic [7:0] out_data;
  logic [3:0] bnn_x;

  int n_checks = 0, n_fail = 0, n_strobe = 0;
  logic [6:0] exp_strobe_q[$];  // {setup, param, bank_hi, x}
  logic [7:0] exp_out_q[$];

  bnn_sequencer #(.PARAM_BITS(PB), .SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_data(cfg_data),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .configured(configured),
    .busy(busy), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .bnn_clk(bnn_clk), .bnn_setup(bnn_setup), .bnn_param(bnn_param),
    .bnn_bank_hi(bnn_bank_hi), .bnn_x(bnn_x), .bnn_y(bnn_y)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bnn_clk) begin
        n_strobe++;
        if (exp_strobe_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL strobe_unexpected: got 0x%0h expected no strobe at %0t",
                   {bnn_setup, bnn_param, bnn_bank_hi, bnn_x}, $time);
        end else begin
          check("strobe", 32'({bnn_setup, bnn_param, bnn_bank_hi, bnn_x}),
                32'(exp_strobe_q.pop_front()));
        end
      end
      if (out_valid && out_ready) begin
        if (exp_out_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL result_unexpected: got 0x%0h expected no result at %0t", out_data, $time);
        end else begin
          check("result", 32'(out_data), 32'(exp_out_q.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) exp_strobe_q.push_back({1'b1, b[i], 1'b0, 4'h0});
  endtask

  // returns 1ns after the handshake edge, i.e. in the first LOAD_SHIFT cycle
  task automatic send_cfg(input logic [7:0] b);
    int t;
    cfg_data  = b;
    cfg_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!cfg_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("cfg_ready_wait", 32'(cfg_ready), 32'd1);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic load(input logic [7:0] b0, input logic [7:0] b1);
    int s0;
    s0 = n_strobe;
    push_byte(b0);
    push_byte(b1);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    @(negedge clk);
    check("load_start", 32'({configured, in_ready, cfg_ready, busy, bnn_setup}), 32'b00111);
    tick();
    send_cfg(b0);
    repeat (16) tick();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("between_bytes", 32'({bnn_clk, bnn_setup, cfg_ready, busy, in_ready}), 32'b01110);
      tick();
    end
    send_cfg(b1);
    repeat (15) tick();
    @(negedge clk);
    check("configured_before_last", 32'(configured), 32'd0);
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    check("load_done", 32'({configured, busy, in_ready, bnn_setup, cfg_ready}), 32'b10100);
    check("load_strobes", 32'(n_strobe - s0), 32'd16);
    tick();
  endtask

  task automatic infer(input logic [7:0] d, input logic [7:0] y);
    int cnt, first;
    exp_strobe_q.push_back({3'b000, d[3:0]});
    exp_strobe_q.push_back({3'b001, d[7:4]});
    exp_out_q.push_back(y);
    bnn_y     = y;
    out_ready = 1'b1;
    in_data   = d;
    in_valid  = 1'b1;
    @(negedge clk);
    check("infer_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    cnt = 0;
    first = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) begin
        cnt++;
        if (first < 0) first = i;
      end
      tick();
    end
    check("infer_valid_cycles", 32'(cnt), 32'd1);
    check("infer_valid_at", 32'(first), 32'd6);
    @(negedge clk);
    check("infer_back_ready", 32'({in_ready, busy, out_valid}), 32'b100);
    out_ready = 1'b0;
    tick();
  endtask

  logic [8:0] exp_tab[7] = '{
    9'b0_0_1110_0_00, 9'b1_0_1110_0_00, 9'b0_1_0111_0_00, 9'b1_1_0111_0_00,
    9'b0_0_0000_0_00, 9'b0_0_0000_0_00, 9'b0_0_0000_1_00
  };  // {bnn_clk, bank_hi, x, out_valid, cfg_ready, bnn_setup}

  initial begin
    bnn_y = 8'h5B;
    #12;
    check("reset_outputs", 32'({cfg_ready, configured, busy, in_ready, out_valid, out_data,
                                bnn_clk, bnn_setup, bnn_param, bnn_bank_hi, bnn_x}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // nothing honoured before configuration
    in_valid = 1'b1; in_data = 8'hAA; cfg_valid = 1'b1; cfg_data = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("pre_cfg_gating", 32'({in_ready, cfg_ready, busy, configured}), 32'd0);
      tick();
    end
    in_valid = 1'b0; cfg_valid = 1'b0;

    load(8'hA5, 8'h3C);

    // inference with latency check, cfg_start during INF_HI, then backpressure
    exp_strobe_q.push_back(7'b000_1110);
    exp_strobe_q.push_back(7'b001_0111);
    exp_out_q.push_back(8'h5B);
    bnn_y = 8'h5B; out_ready = 1'b0; in_data = 8'h7E; in_valid = 1'b1;
    @(negedge clk);
    check("inf_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      cfg_start = (k == 3);
      @(negedge clk);
      check("inf_timing", 32'({bnn_clk, bnn_bank_hi, bnn_x, out_valid, cfg_ready, bnn_setup}),
            32'(exp_tab[k-1]));
      if (k < 7) tick();
    end
    cfg_start = 1'b0;
    check("inf_out_data", 32'(out_data), 32'h5B);
    bnn_y = 8'h00;
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      check("backpressure_hold", 32'({out_valid, out_data, in_ready, busy}), 32'({1'b1, 8'h5B, 1'b0, 1'b1}));
    end
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    check("after_consume", 32'({out_valid, in_ready, busy, configured}), 32'b0101);
    tick();

    infer(8'h19, 8'hC3);

    // reconfigure from READY while an input is pending
    in_valid = 1'b1; in_data = 8'h55;
    load(8'h0F, 8'hF0);
    infer(8'hD2, 8'h4E);

    // reset in the middle of a load, after five strobes
    push_byte(8'hA5);
    repeat (3) void'(exp_strobe_q.pop_back());
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    tick();
    send_cfg(8'hA5);
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    check("reset_mid_load", 32'({cfg_ready, configured, busy, in_ready, out_valid, out_data,
                                 bnn_clk, bnn_setup, bnn_param, bnn_bank_hi, bnn_x}), 32'd0);
    check("strobes_before_reset", 32'(exp_strobe_q.size()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    check("post_reset_idle", 32'({configured, busy, in_ready, cfg_ready}), 32'd0);
    tick();
    load(8'hA5, 8'h3C);
    infer(8'h3C, 8'hA7);

    check("strobe_queue_empty", 32'(exp_strobe_q.size()), 32'd0);
    check("result_queue_empty", 32'(exp_out_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
